// File: rtl/ram_sp_init_pkg.sv
// Shared definitions for the initialising single-port RAM: controller states
// and read-during-write mode selectors.
package ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_sp_init_if.sv
// User-side access bundle for ram_sp_init: request signals from the master,
// read data, read strobe and busy flag back from the RAM.
interface ram_sp_init_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);

  logic              clear;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;

  modport master (
    output clear, we, re, addr, wdata,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  clear, we, re, addr, wdata,
    output rdata, rvalid, busy
  );

endinterface

// File: rtl/ram_sp_init_array.sv
// Plain storage array: one synchronous write port and an unregistered read
// port; the owner registers the read result.
module ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata_comb
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Sampled on the same edge as a write, this returns the pre-write word.
  assign rdata_comb = mem_q[raddr];

endmodule

// File: rtl/ram_sp_init.sv
// Single-port RAM with registered read, a hardware fill sweep after reset or
// on clear, a busy flag while sweeping, and a one-cycle read-valid strobe.
module ram_sp_init
  import ram_pkg::state_t, ram_pkg::ST_INIT, ram_pkg::ST_IDLE;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 5,
  parameter int                RDW_NEW  = ram_pkg::RDW_OLD,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  ram_sp_init_if.slave  bus
);

  localparam int                DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata_comb;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk        (clk),
    .we         (mem_we),
    .waddr      (mem_waddr),
    .wdata      (mem_wdata),
    .raddr      (bus.addr),
    .rdata_comb (rdata_comb)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.addr;
    mem_wdata = bus.wdata;

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = INIT_VAL;
        // The pointer parks on the last word rather than wrapping.
        if (ptr_q == LAST) begin
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.clear) begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end else begin
          mem_we = bus.we;
          if (bus.re) begin
            rvalid_d = 1'b1;
            // Single port: a simultaneous write always targets the read address.
            rdata_d  = (RDW_NEW == ram_pkg::RDW_NEW && bus.we) ? bus.wdata : rdata_comb;
          end
        end
      end
    endcase

    // A reset edge restarts the sweep but leaves the array untouched.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      ptr_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = (state_q == ST_INIT);

endmodule
